// File: rtl/sine_table_loader.sv
// Streams bytes into 32-bit words and writes a 256-word sine table across four
// 64-word banks, keeping a running XOR checksum of every word written.
module sine_table_loader #(
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        csb00,
   output logic        csb10,
   output logic        csb20,
   output logic        csb30,
   output logic        web0,
   output logic [3:0]  wmask0,
   output logic [7:0]  addr0,
   output logic [31:0] din0,
   output logic        busy,
   output logic        done,
   output logic [7:0]  word_idx,
   output logic [31:0] checksum
);

   typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;
   logic [7:0]  idx_q, idx_d;
   logic [31:0] chk_q, chk_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] din_q, din_d;
   logic        s_ready_q, s_ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [3:0]  csb_q, csb_d;
   logic        web_q, web_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [1:0]  lane;

   // Byte lane for the byte being accepted now.
   assign lane = LITTLE_ENDIAN ? cnt_q : ~cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= 2'd0;
         word_q    <= 32'd0;
         idx_q     <= 8'd0;
         chk_q     <= 32'd0;
         addr_q    <= 8'd0;
         din_q     <= 32'd0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         csb_q     <= 4'hF;
         web_q     <= 1'b1;
         wmask_q   <= 4'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         idx_q     <= idx_d;
         chk_q     <= chk_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         csb_q     <= csb_d;
         web_q     <= web_d;
         wmask_q   <= wmask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      idx_d   = idx_q;
      chk_d   = chk_q;
      addr_d  = addr_q;
      din_d   = din_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StCollect;
               cnt_d   = 2'd0;
               idx_d   = 8'd0;
               chk_d   = 32'd0;
            end
         end
         StCollect: begin
            if (s_valid && s_ready_q) begin
               word_d[{lane, 3'b000} +: 8] = s_data;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = StWrite;
                  din_d   = word_d;
                  addr_d  = {2'b00, idx_q[5:0]};
               end
            end
         end
         StWrite: begin
            chk_d   = chk_q ^ din_q;
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == 8'd255) ? StDone : StCollect;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they land in registers.
   always_comb begin
      s_ready_d = (state_d == StCollect);
      busy_d    = (state_d == StCollect) || (state_d == StWrite);
      done_d    = (state_d == StDone);
      web_d     = (state_d != StWrite);
      wmask_d   = (state_d == StWrite) ? 4'hF : 4'h0;
      csb_d     = 4'hF;
      if (state_d == StWrite) begin
         csb_d[idx_d[7:6]] = 1'b0;
      end
   end

   assign s_ready  = s_ready_q;
   assign csb00    = csb_q[0];
   assign csb10    = csb_q[1];
   assign csb20    = csb_q[2];
   assign csb30    = csb_q[3];
   assign web0     = web_q;
   assign wmask0   = wmask_q;
   assign addr0    = addr_q;
   assign din0     = din_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign word_idx = idx_q;
   assign checksum = chk_q;

endmodule

// File: tb/tb_sine_table_loader.sv
// Directed bench for sine_table_loader: cycle-exact vector table for the first
// words, then full-load, restart-from-done and reset corner sequences.
module tb_sine_table_loader;

   logic        clk = 1'b0;
   logic        reset_n, start, s_valid;
   logic [7:0]  s_data;
   logic        s_ready, csb00, csb10, csb20, csb30, web0, busy, done;
   logic [3:0]  wmask0;
   logic [7:0]  addr0, word_idx;
   logic [31:0] din0, checksum;
   logic [3:0]  csb;

   int checks = 0;
   int failures = 0;
   bit mon_on = 1'b0;
   int mon_idx = 0;
   int write_cnt = 0;
   int bank_cnt[4];
   logic [31:0] exp_words[256];
   logic [31:0] exp_chk;

   always #5 clk = ~clk;
   assign csb = {csb30, csb20, csb10, csb00};

   sine_table_loader #(.LITTLE_ENDIAN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .csb00(csb00), .csb10(csb10), .csb20(csb20), .csb30(csb30),
      .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .busy(busy), .done(done),
      .word_idx(word_idx), .checksum(checksum)
   );

   typedef struct {
      logic rst_n; logic st; logic v; logic [7:0] d;
      logic rdy; logic bsy; logic dn; logic [3:0] cs; logic we_n; logic [3:0] wm;
      logic [7:0] addr; logic [31:0] din; logic [7:0] idx; logic [31:0] chk;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 ns later; during a load, audit each write.
   task automatic step();
      logic [7:0] mi;
      logic [3:0] ec;
      @(posedge clk);
      #1;
      if (mon_on && web0 == 1'b0) begin
         mi = mon_idx[7:0];
         ec = 4'hF;
         ec[mi[7:6]] = 1'b0;
         check($sformatf("wr%0d_csb", mon_idx), csb, ec);
         check($sformatf("wr%0d_addr", mon_idx), addr0, {2'b00, mi[5:0]});
         check($sformatf("wr%0d_din", mon_idx), din0, exp_words[mi]);
         check($sformatf("wr%0d_wmask", mon_idx), wmask0, 4'hF);
         for (int b = 0; b < 4; b++) if (!csb[b]) bank_cnt[b]++;
         write_cnt++;
         mon_idx++;
      end
   endtask

   task automatic push_byte(input logic [7:0] d, input int gap);
      bit   ok;
      logic was;
      s_valid = 1'b0;
      repeat (gap) step();
      s_valid = 1'b1;
      s_data  = d;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         was = s_ready;
         step();
         if (was) ok = 1'b1;
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      s_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_csb"}, csb, 4'hF);
      check({tag, "_web"}, web0, 1'b1);
      check({tag, "_wmask"}, wmask0, 4'h0);
      check({tag, "_addr"}, addr0, 8'h00);
      check({tag, "_din"}, din0, 32'h0);
      check({tag, "_rdy"}, s_ready, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_idx"}, word_idx, 8'h00);
      check({tag, "_chk"}, checksum, 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      reset_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      for (int b = 0; b < 4; b++) bank_cnt[b] = 0;

      //           rst st v  d      rdy bsy dn cs    we wm    addr   din           idx    chk
      vecs[0]  = '{0, 0, 0, 8'h00, 0, 0, 0, 4'hF, 1, 4'h0, 8'h00, 32'h0,        8'h00, 32'h0};
      vecs[1]  = '{1, 1, 0, 8'h00, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h0,        8'h00, 32'h0};
      vecs[2]  = '{1, 0, 1, 8'h11, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h0,        8'h00, 32'h0};
      vecs[3]  = '{1, 0, 1, 8'h22, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h0,        8'h00, 32'h0};
      vecs[4]  = '{1, 0, 1, 8'h33, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h0,        8'h00, 32'h0};
      vecs[5]  = '{1, 0, 1, 8'h44, 0, 1, 0, 4'hE, 0, 4'hF, 8'h00, 32'h44332211, 8'h00, 32'h0};
      vecs[6]  = '{1, 0, 0, 8'h00, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h44332211, 8'h01, 32'h44332211};
      vecs[7]  = '{1, 0, 1, 8'hAA, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h44332211, 8'h01, 32'h44332211};
      vecs[8]  = '{1, 0, 0, 8'h00, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h44332211, 8'h01, 32'h44332211};
      vecs[9]  = '{1, 0, 0, 8'h00, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h44332211, 8'h01, 32'h44332211};
      vecs[10] = '{1, 0, 1, 8'hBB, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h44332211, 8'h01, 32'h44332211};
      vecs[11] = '{1, 1, 1, 8'hCC, 1, 1, 0, 4'hF, 1, 4'h0, 8'h00, 32'h44332211, 8'h01, 32'h44332211};
      vecs[12] = '{1, 0, 1, 8'hDD, 0, 1, 0, 4'hE, 0, 4'hF, 8'h01, 32'hDDCCBBAA, 8'h01, 32'h44332211};
      vecs[13] = '{1, 0, 1, 8'hEE, 1, 1, 0, 4'hF, 1, 4'h0, 8'h01, 32'hDDCCBBAA, 8'h02, 32'h99FF99BB};
      vecs[14] = '{1, 0, 1, 8'hEE, 1, 1, 0, 4'hF, 1, 4'h0, 8'h01, 32'hDDCCBBAA, 8'h02, 32'h99FF99BB};
      vecs[15] = '{1, 0, 1, 8'h01, 1, 1, 0, 4'hF, 1, 4'h0, 8'h01, 32'hDDCCBBAA, 8'h02, 32'h99FF99BB};
      vecs[16] = '{1, 0, 1, 8'h02, 1, 1, 0, 4'hF, 1, 4'h0, 8'h01, 32'hDDCCBBAA, 8'h02, 32'h99FF99BB};
      vecs[17] = '{1, 0, 1, 8'h03, 0, 1, 0, 4'hE, 0, 4'hF, 8'h02, 32'h030201EE, 8'h02, 32'h99FF99BB};
      vecs[18] = '{1, 0, 0, 8'h00, 1, 1, 0, 4'hF, 1, 4'h0, 8'h02, 32'h030201EE, 8'h03, 32'h9AFD9855};

      for (int i = 0; i < 19; i++) begin
         reset_n = vecs[i].rst_n; start = vecs[i].st;
         s_valid = vecs[i].v;     s_data = vecs[i].d;
         step();
         check($sformatf("v%0d_rdy", i), s_ready, vecs[i].rdy);
         check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
         check($sformatf("v%0d_done", i), done, vecs[i].dn);
         check($sformatf("v%0d_csb", i), csb, vecs[i].cs);
         check($sformatf("v%0d_web", i), web0, vecs[i].we_n);
         check($sformatf("v%0d_wmask", i), wmask0, vecs[i].wm);
         check($sformatf("v%0d_addr", i), addr0, vecs[i].addr);
         check($sformatf("v%0d_din", i), din0, vecs[i].din);
         check($sformatf("v%0d_idx", i), word_idx, vecs[i].idx);
         check($sformatf("v%0d_chk", i), checksum, vecs[i].chk);
      end

      // Full load: byte i carries i[7:0], with occasional two-cycle gaps.
      start = 1'b0; s_valid = 1'b0; reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      exp_chk = 32'h0;
      for (int k = 0; k < 256; k++) begin
         for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(4*k + j);
         exp_words[k] = w;
         exp_chk ^= w;
      end
      start = 1'b1;
      step();
      start = 1'b0;
      mon_on = 1'b1;
      for (int i = 0; i < 1024; i++) push_byte(8'(i), (i % 7 == 3) ? 2 : 0);
      step();
      mon_on = 1'b0;
      check("full_done", done, 1'b1);
      check("full_busy", busy, 1'b0);
      check("full_rdy", s_ready, 1'b0);
      check("full_web", web0, 1'b1);
      check("full_idx", word_idx, 8'h00);
      check("full_chk", checksum, exp_chk);
      check("full_writes", write_cnt, 256);
      for (int b = 0; b < 4; b++) check($sformatf("full_bank%0d", b), bank_cnt[b], 64);

      // Restart from DONE, then reset in the middle of word 10's write.
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_done", done, 1'b0);
      check("restart_busy", busy, 1'b1);
      check("restart_rdy", s_ready, 1'b1);
      check("restart_idx", word_idx, 8'h00);
      check("restart_chk", checksum, 32'h0);
      for (int i = 0; i < 44; i++) push_byte(8'(100 + i), 0);
      check("w10_web", web0, 1'b0);
      check("w10_csb", csb, 4'hE);
      check("w10_addr", addr0, 8'h0A);
      check("w10_din", din0, 32'h8F8E8D8C);
      reset_n = 1'b0;
      start = 1'b1;
      step();
      check_reset_state("rst_wr");
      reset_n = 1'b1;
      start = 1'b0;
      step();
      check("idle_busy", busy, 1'b0);
      check("idle_rdy", s_ready, 1'b0);

      // A partial word must not survive reset.
      start = 1'b1;
      step();
      start = 1'b0;
      push_byte(8'h01, 0);
      push_byte(8'h02, 0);
      reset_n = 1'b0;
      step();
      check_reset_state("rst_part");
      reset_n = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      push_byte(8'hA1, 0);
      push_byte(8'hA2, 0);
      push_byte(8'hA3, 0);
      check("part_no_write", web0, 1'b1);
      push_byte(8'hA4, 0);
      check("part_web", web0, 1'b0);
      check("part_din", din0, 32'hA4A3A2A1);
      check("part_addr", addr0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
